crc_serial_param: RTL and testbench
===================================

Name: crc_serial_param

Overview:
- Parametrised serial CRC engine; next generation of the fixed 8-bit LFSR CRC block.
- Width, polynomial, seed and output bit order are parameters.
- Adds a message bit counter, a busy flag, a defined abort rule and optional parallel result output.
- Sits between the serial frame source and the serial link encoder: it absorbs message bits while ACTIVE is high, then serialises the CRC with Valid.

Parameters:
- CRC_W, 8, CRC/LFSR width in bits; legal range 4..32.
- POLY, 8'h44, tap mask; bit i set means stage i receives fb XOR. Width CRC_W; bit CRC_W-1 is ignored.
- SEED, 8'hD8, LFSR value loaded at reset and after every completed or aborted frame. Width CRC_W.
- MSB_FIRST, 0, 0 = CRC shifted out LSB first; 1 = MSB first.
- CNT_W, 16, width of the message bit counter.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
- ACTIVE  in  1  high = DATA carries a valid message bit this cycle.
- DATA  in  1  serial message bit.
- CRC  out  1  serial CRC bit, meaningful only while Valid=1.
- Valid  out  1  high for exactly CRC_W consecutive cycles while CRC is shifted out.
- Busy  out  1  high while in the SHIFT_OUT state.
- BIT_CNT  out  CNT_W  number of message bits absorbed in the current or last frame.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - LFSR is loaded with SEED; state goes to IDLE.
  - CRC=0, Valid=0, Busy=0, BIT_CNT=0.
  - Reset overrides everything, including mid-frame and mid-shift-out.
- LFSR update, applied on each cycle with ACTIVE=1 in IDLE or ABSORB:
  - fb = DATA ^ r[0]
  - r'[CRC_W-1] = fb
  - for i < CRC_W-1: r'[i] = r[i+1] ^ (POLY[i] & fb)
- States:
  - IDLE:
    - ACTIVE=1: apply the update, set BIT_CNT=1, go to ABSORB.
    - ACTIVE=0: hold; BIT_CNT keeps its value from the last frame.
  - ABSORB:
    - ACTIVE=1: apply the update; BIT_CNT increments and saturates at all-ones.
    - ACTIVE=0: go to SHIFT_OUT and start the output counter at 0.
  - SHIFT_OUT, CRC_W cycles:
    - Valid=1 and Busy=1 on every cycle.
    - CRC = r[0] with LSB first (register shifts right), or r[CRC_W-1] with MSB first (shifts left).
    - After the CRC_W-th bit: reload SEED and go to IDLE; Valid drops on the next cycle.
- Latency: the first CRC bit appears, with Valid=1, the cycle after ACTIVE is sampled low. Frames can run back to back; ACTIVE may rise on the first IDLE cycle.
- CRC, Valid and Busy are registered outputs.
- ACTIVE=1 during SHIFT_OUT: ignored, with no LFSR update and no count. The shift-out always completes.
  - The bits are dropped; the upstream source must honour Busy.
- Minimum frame is 1 bit. A frame of 0 bits (ACTIVE never high) produces no output.
- BIT_CNT saturating at 2^CNT_W-1 does not affect the CRC.

Optional Feature:
- Macro CRC_PAR_OUT_EN.
- Defined:
  - Adds output CRC_PAR [CRC_W-1:0] and output CRC_PAR_VLD [1].
  - On the ABSORB->SHIFT_OUT transition, CRC_PAR latches the final LFSR value, unreflected regardless of MSB_FIRST. CRC_PAR_VLD pulses high for one cycle, coincident with the first Valid cycle.
  - CRC_PAR holds its value until the next frame ends. Reset clears both outputs to 0.
- Undefined: neither port exists; serial behaviour is identical in both builds.

Decomposition:
- Package crc_pkg holds:
  - the state enum (IDLE, ABSORB, SHIFT_OUT);
  - default constants CRC8_POLY=8'h44 and CRC8_SEED=8'hD8;
  - a function lfsr_step(r, data, poly) implementing the update equation.
- One sub-module is natural: crc_lfsr_core, holding the LFSR register with load-seed, step and shift controls. The FSM and counters stay in the top level.

Test Plan:
- Reset with defaults, then 1 bit DATA=0 -> LFSR 0xD8->0x6C. Valid is high for 8 cycles; CRC sequence LSB first is 0,0,1,1,0,1,1,0. BIT_CNT=1.
- SEED=0, 1 bit DATA=1 -> LFSR=0xC4. Serial output LSB first is 0,0,1,0,0,0,1,1. With CRC_PAR_OUT_EN: CRC_PAR=0xC4 and CRC_PAR_VLD is a one-cycle pulse.
- Ten 8-bit vectors from the existing DATA_h/Expec_Out_h files, defaults, LSB-first data -> each 8-bit serial output matches the expected byte. A 16-bit message with CRC_W=16 and POLY=16'h1021 matches the reference model.
- RST asserted on the 3rd SHIFT_OUT cycle -> Valid=0 next edge, LFSR=SEED, BIT_CNT=0. A following frame gives a correct CRC.
- ACTIVE raised during SHIFT_OUT -> those bits are ignored, the CRC is unchanged, and Busy stays high all 8 cycles. A back-to-back frame started on the first IDLE cycle gives a correct CRC.
- MSB_FIRST=1, SEED=0, DATA=1 -> serial output 1,1,0,0,0,1,0,0.

Source files
------------

// File: rtl/crc_pkg.sv
// ============================================================================
// crc_pkg: FSM states, CRC-8 default constants and the LFSR step function.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package crc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ABSORB    = 2'd1,
    SHIFT_OUT = 2'd2
  } crc_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h44;
  localparam logic [7:0] CRC8_SEED = 8'hD8;

  // One message bit into a w-bit Galois LFSR held in the low bits of a 32-bit word.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r,
                                            input logic        data,
                                            input logic [31:0] poly,
                                            input int unsigned w = 8);
    logic        fb;
    logic [31:0] top_bit;
    logic [31:0] lo_mask;
    logic [31:0] nxt;
    fb      = data ^ r[0];
    top_bit = 32'h1 << (w - 1);
    lo_mask = top_bit - 32'h1;
    nxt     = (r & (lo_mask | top_bit)) >> 1;
    if (fb) begin
      nxt = nxt ^ (poly & lo_mask) ^ top_bit;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_lfsr_core.sv
// ============================================================================
// crc_lfsr_core: CRC LFSR register with seed load, message step and output shift.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_lfsr_core
  import crc_pkg::*;
#(
  parameter int               CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] SEED      = CRC_W'(CRC8_SEED),
  parameter bit               MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             data_i,
  input  logic             shift_i,
  output logic [CRC_W-1:0] lfsr_o,
  output logic             out_bit_o
);

  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_d;
  logic [CRC_W-1:0] shifted;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted   = {lfsr_q[CRC_W-2:0], 1'b0};
    assign out_bit_o = lfsr_q[CRC_W-1];
  end else begin : g_lsb_first
    assign shifted   = {1'b0, lfsr_q[CRC_W-1:1]};
    assign out_bit_o = lfsr_q[0];
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = CRC_W'(lfsr_step(32'(lfsr_q), data_i, 32'(POLY), CRC_W));
    end else if (shift_i) begin
      lfsr_d = shifted;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/crc_serial_param.sv
// ============================================================================
// crc_serial_param: serial CRC engine; absorbs bits while ACTIVE, then shifts the CRC out.
// Optional parallel result via macro CRC_PAR_OUT_EN. Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_serial_param
  import crc_pkg::*;
#(
  parameter int               CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] SEED      = CRC_W'(CRC8_SEED),
  parameter bit               MSB_FIRST = 1'b0,
  parameter int               CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ACTIVE,
  input  logic             DATA,
  output logic             CRC,
  output logic             Valid,
  output logic             Busy,
  output logic [CNT_W-1:0] BIT_CNT
`ifdef CRC_PAR_OUT_EN
  ,
  output logic [CRC_W-1:0] CRC_PAR,
  output logic             CRC_PAR_VLD
`endif
);

  localparam int OCNT_W = $clog2(CRC_W);

  crc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  logic              crc_q, crc_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              load, step, shift, cap;
  logic [CRC_W-1:0]  lfsr;
  logic              out_bit;

  crc_lfsr_core #(
    .CRC_W     (CRC_W),
    .POLY      (POLY),
    .SEED      (SEED),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (load),
    .step_i    (step),
    .data_i    (DATA),
    .shift_i   (shift),
    .lfsr_o    (lfsr),
    .out_bit_o (out_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ocnt_d  = ocnt_q;
    crc_d   = crc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    load    = 1'b0;
    step    = 1'b0;
    shift   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ACTIVE) begin
          step    = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        if (ACTIVE) begin
          step = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // First CRC bit is presented on the same edge the frame closes.
          state_d = SHIFT_OUT;
          ocnt_d  = '0;
          crc_d   = out_bit;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          shift   = 1'b1;
          cap     = 1'b1;
        end
      end
      SHIFT_OUT: begin
        if (ocnt_q == OCNT_W'(CRC_W - 1)) begin
          state_d = IDLE;
          crc_d   = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          load    = 1'b1;
        end else begin
          ocnt_d = ocnt_q + OCNT_W'(1);
          crc_d  = out_bit;
          shift  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        crc_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        load    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign CRC     = crc_q;
  assign Valid   = valid_q;
  assign Busy    = busy_q;
  assign BIT_CNT = cnt_q;

`ifdef CRC_PAR_OUT_EN
  logic [CRC_W-1:0] par_q;
  logic             par_vld_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q     <= '0;
      par_vld_q <= 1'b0;
    end else begin
      par_vld_q <= cap;
      if (cap) begin
        par_q <= lfsr;
      end
    end
  end

  assign CRC_PAR     = par_q;
  assign CRC_PAR_VLD = par_vld_q;
`else
  logic unused_par;
  assign unused_par = ^{lfsr, cap};
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc_serial_param.sv
// ============================================================================
// tb_crc_serial_param: four engine configurations driven by one random stream,
// checked every cycle against a frame-level reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_crc_serial_param;

  localparam int N = 4;
  localparam int        W_C    [N] = '{8, 8, 8, 16};
  localparam bit [31:0] POLY_C [N] = '{32'h44, 32'h44, 32'h44, 32'h1021};
  localparam bit [31:0] SEED_C [N] = '{32'hD8, 32'h0, 32'h0, 32'hFFFF};
  localparam bit        MSB_C  [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int        CNT_C  [N] = '{16, 16, 3, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic act = 1'b0;
  logic dat = 1'b0;

  always #5 clk = ~clk;

  logic        crc_w   [N];
  logic        valid_w [N];
  logic        busy_w  [N];
  logic [15:0] cnt_w   [N];
`ifdef CRC_PAR_OUT_EN
  logic [15:0] par_w   [N];
  logic        parv_w  [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int           W = W_C[g];
    localparam logic [W-1:0] P = POLY_C[g][W-1:0];
    localparam logic [W-1:0] S = SEED_C[g][W-1:0];
    logic [CNT_C[g]-1:0] cnt_l;
`ifdef CRC_PAR_OUT_EN
    logic [W-1:0] par_l;
    logic         parv_l;
`endif
    crc_serial_param #(
      .CRC_W     (W),
      .POLY      (P),
      .SEED      (S),
      .MSB_FIRST (MSB_C[g]),
      .CNT_W     (CNT_C[g])
    ) u_dut (
      .CLK     (clk),
      .RST     (rst),
      .ACTIVE  (act),
      .DATA    (dat),
      .CRC     (crc_w[g]),
      .Valid   (valid_w[g]),
      .Busy    (busy_w[g]),
      .BIT_CNT (cnt_l)
`ifdef CRC_PAR_OUT_EN
      ,
      .CRC_PAR     (par_l),
      .CRC_PAR_VLD (parv_l)
`endif
    );
    assign cnt_w[g] = 16'(cnt_l);
`ifdef CRC_PAR_OUT_EN
    assign par_w[g]  = 16'(par_l);
    assign parv_w[g] = parv_l;
`endif
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", name, k, $time, got, exp);
    end
  endtask

  // Reference model: frame-level view of the spec (message accumulation, then W serial bits).
  int unsigned m_r [N], m_cnt [N], m_word [N], m_left [N], m_par [N];
  bit          m_frame [N], m_valid [N], m_crc [N], m_parv [N];
  bit          m_init = 1'b0;

  function automatic int unsigned ref_step(input int unsigned r, input bit d, input int k);
    int unsigned n;
    bit          fb;
    n  = 0;
    fb = d ^ r[0];
    for (int i = 0; i < W_C[k] - 1; i++) n[i] = r[i+1] ^ (POLY_C[k][i] & fb);
    n[W_C[k]-1] = fb;
    return n;
  endfunction

  function automatic bit ser_bit(input int k, input int unsigned word, input int unsigned idx);
    return MSB_C[k] ? word[W_C[k] - 1 - idx] : word[idx];
  endfunction

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      m_parv[k] = 1'b0;
      if (rst) begin
        m_r[k] = SEED_C[k]; m_cnt[k] = 0; m_frame[k] = 0; m_valid[k] = 0;
        m_crc[k] = 0; m_left[k] = 0; m_par[k] = 0;
      end else if (m_valid[k]) begin
        if (m_left[k] > 0) begin
          m_crc[k] = ser_bit(k, m_word[k], W_C[k] - m_left[k]);
          m_left[k]--;
        end else begin
          m_valid[k] = 0; m_crc[k] = 0; m_r[k] = SEED_C[k];
        end
      end else if (m_frame[k]) begin
        if (act) begin
          m_r[k] = ref_step(m_r[k], dat, k);
          if (m_cnt[k] < (1 << CNT_C[k]) - 1) m_cnt[k]++;
        end else begin
          m_frame[k] = 0; m_valid[k] = 1; m_parv[k] = 1;
          m_par[k] = m_r[k]; m_word[k] = m_r[k];
          m_crc[k] = ser_bit(k, m_word[k], 0);
          m_left[k] = W_C[k] - 1;
        end
      end else if (act) begin
        m_r[k] = ref_step(m_r[k], dat, k);
        m_cnt[k] = 1; m_frame[k] = 1;
      end
    end
    m_init = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int unsigned cap [N], cap_n [N], last_word [N], last_par [N];

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      for (int k = 0; k < N; k++) begin
        chk("valid", k, 32'(valid_w[k]), 32'(m_valid[k]));
        chk("busy", k, 32'(busy_w[k]), 32'(m_valid[k]));
        if (m_valid[k]) chk("crc_bit", k, 32'(crc_w[k]), 32'(m_crc[k]));
        chk("bit_cnt", k, 32'(cnt_w[k]), m_cnt[k]);
`ifdef CRC_PAR_OUT_EN
        chk("crc_par_vld", k, 32'(parv_w[k]), 32'(m_parv[k]));
        chk("crc_par", k, 32'(par_w[k]), m_par[k]);
        if (parv_w[k] === 1'b1) last_par[k] = 32'(par_w[k]);
`endif
        if (valid_w[k] === 1'b1) begin
          if (MSB_C[k]) cap[k] = (cap[k] << 1) | 32'(crc_w[k]);
          else          cap[k] = (cap[k] >> 1) | (32'(crc_w[k]) << (W_C[k] - 1));
          cap_n[k]++;
          if (cap_n[k] == W_C[k]) begin
            last_word[k] = cap[k] & ((32'h1 << W_C[k]) - 1);
            cap_n[k] = 0;
          end
        end else begin
          cap_n[k] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_last();
    for (int k = 0; k < N; k++) begin
      last_word[k] = 32'hFFFF_FFFF;
      last_par[k]  = 32'hFFFF_FFFF;
    end
  endtask

  task automatic drive_bits(input int n, input logic [31:0] bits, input bit rnd);
    for (int i = 0; i < n; i++) begin
      act = 1'b1;
      dat = rnd ? 1'($urandom_range(0, 1)) : bits[i];
      tick();
    end
    act = 1'b0;
    dat = 1'b0;
  endtask

  // which < 0 waits for every instance to go idle.
  task automatic wait_idle(input int which);
    int  t;
    bit  any;
    t = 0;
    tick();
    forever begin
      any = 1'b0;
      for (int k = 0; k < N; k++) if ((which < 0 || which == k) && valid_w[k] !== 1'b0) any = 1'b1;
      if (!any) break;
      if (t >= 100) begin
        errors++;
        $display("FAIL wait_idle: valid still high after %0d cycles, required low", t);
        break;
      end
      tick();
      t++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_last();
    for (int k = 0; k < N; k++) begin cap[k] = 0; cap_n[k] = 0; end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_valid", 0, 32'(valid_w[0]), 0);
    chk("reset_cnt", 0, 32'(cnt_w[0]), 0);

    // 1-bit frame, DATA=0
    clear_last();
    drive_bits(1, 32'h0, 1'b0);
    wait_idle(-1);
    chk("one_bit_d0", 0, last_word[0], 32'h6C);
    chk("one_bit_d0", 1, last_word[1], 32'h00);
    chk("one_bit_d0", 3, last_word[3], 32'hEFDE);
    chk("one_bit_cnt", 0, 32'(cnt_w[0]), 1);

    // 1-bit frame, DATA=1
    clear_last();
    drive_bits(1, 32'h1, 1'b0);
    wait_idle(-1);
    chk("one_bit_d1", 0, last_word[0], 32'hA8);
    chk("one_bit_d1_lsb", 1, last_word[1], 32'hC4);
    chk("one_bit_d1_msb", 2, last_word[2], 32'hC4);
    chk("one_bit_d1", 3, last_word[3], 32'h7FFF);
`ifdef CRC_PAR_OUT_EN
    chk("par_literal", 1, last_par[1], 32'hC4);
    chk("par_literal", 2, last_par[2], 32'hC4);
`endif

    // Random 8-bit frames, a 16-bit frame and random-length frames
    repeat (10) begin drive_bits(8, 32'h0, 1'b1); wait_idle(-1); end
    drive_bits(16, 32'h0, 1'b1);
    wait_idle(-1);
    repeat (12) begin drive_bits(int'($urandom_range(1, 40)), 32'h0, 1'b1); wait_idle(-1); end

    // ACTIVE during shift-out, then a frame starting on the first IDLE cycle
    drive_bits(8, 32'h0, 1'b1);
    tick();
    repeat (5) begin act = 1'b1; dat = 1'($urandom_range(0, 1)); tick(); end
    act = 1'b0;
    wait_idle(0);
    drive_bits(5, 32'h0, 1'b1);
    wait_idle(-1);

    // Reset on the 3rd shift-out cycle, then a clean frame
    drive_bits(8, 32'h0, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_shift_rst_valid", 0, 32'(valid_w[0]), 0);
    chk("mid_shift_rst_cnt", 0, 32'(cnt_w[0]), 0);
    clear_last();
    drive_bits(1, 32'h0, 1'b0);
    wait_idle(-1);
    chk("after_rst_frame", 0, last_word[0], 32'h6C);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
